// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Adds two WIDTH-bit operands plus a carry-in, two bits (one digit) per clock,
// LSB digit first. Each digit is added through a 32-entry lookup table indexed
// by {a_digit, b_digit, carry}. A request is accepted in IDLE and the block
// spends N = WIDTH/2 cycles in RUN. It then spends one cycle in DONE, where the
// registered result is valid and done pulses.
//
// Parameters
//   WIDTH  operand width in bits; must be even and at least 2
//
// Ports
//   clk    clock; all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   start  request a new addition (ignored outside IDLE)
//   a, b   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while digits are being processed (RUN)
//   done   one-cycle pulse marking a valid result (DONE)
//   sum    registered result, low WIDTH bits
//   cout   registered final carry
//   ovf    registered two's-complement overflow
//          (present only when DIGIT_SERIAL_OVF_EN is defined)
//
// Configuration
//   DIGIT_SERIAL_OVF_EN  adds the ovf output and its logic
// -----------------------------------------------------------------------------
module digit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("digit_serial_adder: WIDTH must be even and at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Working copies of the operands, so later input changes cannot disturb
    // an operation in progress.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] wsum_q, wsum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;

    // Result registers; these only change on entry to DONE.
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [1:0]       a_dig, b_dig;
    logic [2:0]       lut_out;
    logic             last_digit;
    logic [WIDTH-1:0] wsum_upd;

    // 2-bit digit add with carry: index {a_digit, b_digit, carry_in},
    // entry {carry_out, sum_digit}.
    function automatic logic [2:0] digit_lut(input logic [4:0] idx);
        logic [2:0] r;
        unique case (idx)
            5'd0:  r = 3'd0;
            5'd1:  r = 3'd1;
            5'd2:  r = 3'd1;
            5'd3:  r = 3'd2;
            5'd4:  r = 3'd2;
            5'd5:  r = 3'd3;
            5'd6:  r = 3'd3;
            5'd7:  r = 3'd4;
            5'd8:  r = 3'd1;
            5'd9:  r = 3'd2;
            5'd10: r = 3'd2;
            5'd11: r = 3'd3;
            5'd12: r = 3'd3;
            5'd13: r = 3'd4;
            5'd14: r = 3'd4;
            5'd15: r = 3'd5;
            5'd16: r = 3'd2;
            5'd17: r = 3'd3;
            5'd18: r = 3'd3;
            5'd19: r = 3'd4;
            5'd20: r = 3'd4;
            5'd21: r = 3'd5;
            5'd22: r = 3'd5;
            5'd23: r = 3'd6;
            5'd24: r = 3'd3;
            5'd25: r = 3'd4;
            5'd26: r = 3'd4;
            5'd27: r = 3'd5;
            5'd28: r = 3'd5;
            5'd29: r = 3'd6;
            5'd30: r = 3'd6;
            5'd31: r = 3'd7;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Digit datapath
    // -------------------------------------------------------------------------
    always_comb begin
        a_dig      = a_q[{cnt_q, 1'b0} +: 2];
        b_dig      = b_q[{cnt_q, 1'b0} +: 2];
        lut_out    = digit_lut({a_dig, b_dig, carry_q});
        last_digit = (cnt_q == CntW'(N - 1));

        wsum_upd                    = wsum_q;
        wsum_upd[{cnt_q, 1'b0} +: 2] = lut_out[1:0];
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_digit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StRun:   busy = 1'b1;
            StDone:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Working and result register next-state
    // -------------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        wsum_d  = wsum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        if ((state_q == StIdle) && start) begin
            a_d     = a;
            b_d     = b;
            wsum_d  = '0;
            cnt_d   = '0;
            carry_d = cin;
        end else if (state_q == StRun) begin
            wsum_d  = wsum_upd;
            carry_d = lut_out[2];
            if (last_digit) begin
                // Park the counter at zero rather than letting it wrap.
                cnt_d  = '0;
                sum_d  = wsum_upd;
                cout_d = lut_out[2];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            wsum_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            wsum_q  <= wsum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef DIGIT_SERIAL_OVF_EN
    // Signed overflow = carry into MSB XOR carry out of MSB. The carry into
    // the MSB is recovered from the MSB sum bit: sum = a ^ b ^ carry_in.
    logic ovf_q, ovf_d;
    logic msb_cin;

    always_comb begin
        msb_cin = a_dig[1] ^ b_dig[1] ^ lut_out[1];
        ovf_d   = ovf_q;
        if ((state_q == StRun) && last_digit) begin
            ovf_d = msb_cin ^ lut_out[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Directed test for digit_serial_adder at WIDTH=8. Each accepted request pushes
// its expected result and due cycle into a scoreboard queue; a monitor pops and
// compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

    localparam int unsigned W = 8;
    localparam int unsigned N = W / 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    digit_serial_adder #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef DIGIT_SERIAL_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

`ifndef DIGIT_SERIAL_OVF_EN
    assign ovf = 1'b0;
`endif

    typedef struct {
        string        name;
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_sum"}, 32'(sum), 32'(e.s));
                chk({e.name, "_cout"}, 32'(cout), 32'(e.c));
                chk({e.name, "_latency"}, cyc, e.due);
`ifdef DIGIT_SERIAL_OVF_EN
                chk({e.name, "_ovf"}, 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    task automatic push_exp(input string nm, input logic [W-1:0] es, input logic ec,
                            input logic eo, input int due);
        exp_t e;
        e.name = nm;
        e.s    = es;
        e.c    = ec;
        e.o    = eo;
        e.due  = due;
        sb.push_back(e);
    endtask

    // Drive a request at the falling edge; returns 1 time unit after acceptance.
    task automatic issue(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [W-1:0] es, input logic ec,
                         input logic eo);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(nm, es, ec, eo, cyc + N);
    endtask

    // n RUN cycles: busy high, previous result still held.
    task automatic run_busy(input int n, input logic [W-1:0] ps, input logic pc);
        repeat (n) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("sum_hold", 32'(sum), 32'(ps));
            chk("cout_hold", 32'(cout), 32'(pc));
            @(posedge clk);
            #1;
        end
    endtask

    // In DONE: check the pulse, then step back to IDLE.
    task automatic finish_op();
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        chk("done_single", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic full_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input logic [W-1:0] es, input logic ec,
                           input logic eo, input logic [W-1:0] ps, input logic pc);
        issue(nm, av, bv, cv, es, ec, eo);
        run_busy(N, ps, pc);
        finish_op();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Reset values before any clock edge.
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        full_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 8'h00, 1'b0);
        full_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h96, 1'b0);
        full_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1);

        // Start pulsed and operands changed during RUN must be ignored.
        issue("ignored", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        cin   = 1'b1;
        run_busy(1, 8'hFF, 1'b1);
        start = 1'b0;
        a     = 8'hE7;
        run_busy(N - 1, 8'hFF, 1'b1);
        finish_op();
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("no_requeue", 32'(busy), 32'd0);
        end

        // Reset two cycles into RUN aborts with no done pulse.
        issue("aborted", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_busy(2, 8'h96, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        // Release reset together with start: the very next edge must accept.
        rst_n = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp("post_rst", 8'h04, 1'b0, 1'b0, cyc + N);
        run_busy(N, 8'h00, 1'b0);
        finish_op();

        full_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'h04, 1'b0);
        full_op("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0);
        full_op("no_ovf", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 8'h00, 1'b1);

        // Start held high: accepted again on the first edge back in IDLE.
        @(negedge clk);
        a     = 8'h03;
        b     = 8'h04;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp("held_1", 8'h07, 1'b0, 1'b0, cyc + N);
        run_busy(N, 8'h30, 1'b0);
        chk("held_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        chk("held_idle_gap", 32'(busy), 32'd0);
        push_exp("held_2", 8'h07, 1'b0, 1'b0, cyc + 1 + N);
        @(posedge clk);
        #1;
        start = 1'b0;
        run_busy(N, 8'h07, 1'b0);
        finish_op();

        // Drain with a bounded wait.
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are even and at least 2; number of digits N = WIDTH/2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new addition; sampled on the rising edge.
REQ-005 SHALL have ports a and b, input, WIDTH bits each: operands, captured when start is accepted.
REQ-006 SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while digits are being processed.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port sum, output, WIDTH bits: registered result.
REQ-010 SHALL have port cout, output, 1 bit: registered final carry.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 SHALL capture a, b and cin into working registers, clear the digit counter to 0, and move to RUN; start=0 SHALL keep the FSM in IDLE.
REQ-013 In RUN, each edge SHALL add digit i as follows: working a[2i+1:2i] + working b[2i+1:2i] + carry. This is a 2-bit digit add with carry, realised as a 32-entry lookup table indexed by {a_digit, b_digit, carry}, producing a 3-bit {carry, sum_digit}.
REQ-014 The sum digit SHALL be stored in working-sum bits [2i+1:2i], the carry register SHALL be updated, and i SHALL increment; digits are processed LSB first.
REQ-015 On the edge that processes digit N-1, the FSM SHALL move to DONE, load sum from the working sum and load cout from the final carry.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: done is high during the cycle following the N-th rising edge after the accepting edge.
REQ-018 busy SHALL equal 1 exactly while in RUN; done SHALL equal 1 exactly while in DONE.
REQ-019 start SHALL be ignored in RUN and DONE, so there is no queuing; a start held high SHALL be accepted again on the first edge in IDLE.
REQ-020 sum and cout SHALL hold the previous result during RUN and IDLE, changing only on entry to DONE.
REQ-021 Operand changes after acceptance SHALL NOT affect the result in progress.
REQ-022 The result SHALL equal a + b + cin modulo 2^(WIDTH+1), with sum holding the low WIDTH bits and cout the top bit, including the all-ones wrap-around case.

Reset
REQ-023 While rst_n=0, the FSM SHALL be in IDLE, and busy, done, sum, cout, the digit counter, the carry and all working registers SHALL be 0, independent of clk.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; after rst_n rises, the block SHALL accept start on the first clock edge.

Configuration
REQ-025 With macro DIGIT_SERIAL_OVF_EN defined, the block SHALL add output port ovf, 1 bit, registered alongside sum and reset to 0. ovf is the two's-complement signed overflow: carry into the MSB XOR carry out of the MSB, derived from the last digit's operand MSBs and sum MSB.
REQ-026 Without DIGIT_SERIAL_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, N=4)
REQ-027 Basic add: start with a=8'h5A, b=8'h3C, cin=0 -> busy for 4 cycles, then done pulses for 1 cycle with sum=8'h96 and cout=0.
REQ-028 Carry-out cases:
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-029 Ignored start and stable inputs: pulse start again and change a/b during RUN of the 8'h5A+8'h3C operation -> exactly one done pulse with sum=8'h96; no second operation starts.
REQ-030 Reset mid-operation: drop rst_n after 2 RUN cycles -> all outputs read 0 immediately with no done pulse; a following start with a=8'h01, b=8'h02, cin=1 -> sum=8'h04, cout=0.
REQ-031 Overflow (DIGIT_SERIAL_OVF_EN defined):
- 8'h7F + 8'h01 -> ovf=1, cout=0.
- 8'h80 + 8'h80 -> sum=8'h00, cout=1, ovf=1.
- 8'h10 + 8'h20 -> ovf=0.
